// File: rtl/lut_ram_ctrl_pkg.sv
// Shared types for the LUT RAM write controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package lut_ram_ctrl_pkg;

  // Controller mode: sweeping CLEAR_VALUE into every entry, or passing requester writes through.
  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } state_e;

endpackage : lut_ram_ctrl_pkg

// File: rtl/lut_ram_write_ctrl.sv
// Write-port controller for a LUT RAM: clears all entries after reset or on request, then forwards requester writes.
// Latency: zero added latency; an accepted write reaches the RAM on the same clock edge. A full clear takes DEPTH cycles.
// Backpressure: wr_ready is low while clearing and during a clear_req cycle. Macro LUT_RAM_CLEAR_EN enables the clear engine.
module lut_ram_write_ctrl
  import lut_ram_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     clear_req,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic                     ram_write,
  output logic [WIDTH-1:0]         new_ram_data,
  output logic                     init_done,
  output logic                     clear_done
);

  localparam int AW = $clog2(DEPTH);

`ifdef LUT_RAM_CLEAR_EN

  // Last entry index; DEPTH need not be a power of two, so the counter wraps explicitly here.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            clear_done_q, clear_done_d;
  logic            ram_write_raw;

  // State, clear counter and done-pulse registers; reset aborts any clear and restarts from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEARING;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Next-state logic and RAM write-port mux; idle outputs follow the requester to avoid X on the RAM port.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    clear_done_d  = 1'b0;
    wr_ready      = 1'b0;
    ram_write_raw = 1'b0;
    waddr         = wr_addr;
    new_ram_data  = wr_data;
    case (state_q)
      CLEARING: begin
        // clear_req is deliberately ignored here: a clear already in flight is not restarted.
        ram_write_raw = 1'b1;
        waddr         = cnt_q;
        new_ram_data  = CLEAR_VALUE;
        if (cnt_q == LAST_ADDR) begin
          state_d      = READY;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        // A clear request takes priority over a coincident write, which stays pending.
        wr_ready      = !clear_req;
        ram_write_raw = wr_valid & !clear_req;
        if (clear_req) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEARING;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset parks the FSM in CLEARING; mask the write enable so nothing is written while held in reset.
  assign ram_write  = ram_write_raw & rst_n;
  assign init_done  = (state_q == READY);
  assign clear_done = clear_done_q;

`else

  // Without the clear engine the controller is a pure pass-through that is always ready.
  logic unused_cfg;

  assign wr_ready     = 1'b1;
  assign ram_write    = wr_valid;
  assign waddr        = wr_addr;
  assign new_ram_data = wr_data;
  assign init_done    = 1'b1;
  assign clear_done   = 1'b0;
  assign unused_cfg   = ^{clk, rst_n, clear_req, CLEAR_VALUE, AW[0]};

`endif

endmodule : lut_ram_write_ctrl

// File: tb/tb_lut_ram_write_ctrl.sv
// Directed self-checking bench for lut_ram_write_ctrl with a behavioural LUT RAM model per instance.
// Latency: checks combinational outputs mid-cycle and RAM contents after the writing edge.
// Backpressure: exercises wr_ready low during clear and on clear_req; covers builds with and without LUT_RAM_CLEAR_EN.
module tb_lut_ram_write_ctrl;

  logic        clk = 1'b0;
  int          tests_run = 0;
  int          tests_failed = 0;

  // DEPTH=32 instance
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        clear_req = 1'b0;
  logic [4:0]  waddr;
  logic        ram_write;
  logic [31:0] new_ram_data;
  logic        init_done;
  logic        clear_done;

  // DEPTH=24 instance
  logic        rst_n_b = 1'b0;
  logic        wr_valid_b = 1'b0;
  logic [4:0]  wr_addr_b = '0;
  logic [31:0] wr_data_b = '0;
  logic        wr_ready_b;
  logic        clear_req_b = 1'b0;
  logic [4:0]  waddr_b;
  logic        ram_write_b;
  logic [31:0] new_ram_data_b;
  logic        init_done_b;
  logic        clear_done_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [24];

  always #5 clk = ~clk;

  lut_ram_write_ctrl #(.WIDTH(32), .DEPTH(32), .CLEAR_VALUE(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear_req(clear_req), .waddr(waddr), .ram_write(ram_write),
    .new_ram_data(new_ram_data), .init_done(init_done), .clear_done(clear_done)
  );

  lut_ram_write_ctrl #(.WIDTH(32), .DEPTH(24), .CLEAR_VALUE(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b), .clear_req(clear_req_b), .waddr(waddr_b), .ram_write(ram_write_b),
    .new_ram_data(new_ram_data_b), .init_done(init_done_b), .clear_done(clear_done_b)
  );

  // RAM models: garbage while in reset, so a clear must actually overwrite every entry.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (ram_write) begin
      mem_a[waddr] <= new_ram_data;
    end
  end

  always @(posedge clk) begin
    if (!rst_n_b) begin
      for (int i = 0; i < 24; i++) mem_b[i] <= 32'h5A5A_0000 | 32'(i);
    end else if (ram_write_b && waddr_b < 5'd24) begin
      mem_b[waddr_b] <= new_ram_data_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BAD_0BAD; clear_req = 1'b0;
    repeat (2) step();
    at_neg();
`ifdef LUT_RAM_CLEAR_EN
    tests_run++; if (ram_write !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_write: got %b want 0", ram_write); end
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL reset_init_done: got %b want 0", init_done); end
`else
    tests_run++; if (ram_write !== 1'b1) begin tests_failed++; $display("FAIL reset_ram_write: got %b want 1", ram_write); end
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    tests_run++; if (init_done !== 1'b1) begin tests_failed++; $display("FAIL reset_init_done: got %b want 1", init_done); end
    tests_run++; if (waddr !== 5'd9) begin tests_failed++; $display("FAIL reset_waddr: got %0d want 9", waddr); end
`endif
    tests_run++; if (clear_done !== 1'b0) begin tests_failed++; $display("FAIL reset_clear_done: got %b want 0", clear_done); end
    wr_valid = 1'b0;
  endtask

`ifdef LUT_RAM_CLEAR_EN
  // Runs a full 32-entry clear starting in the current cycle, checking every write.
  task automatic run_clear32(input string tag);
    for (int i = 0; i < 32; i++) begin
      at_neg();
      tests_run++; if (ram_write !== 1'b1 || waddr !== 5'(i) || new_ram_data !== 32'h0) begin
        tests_failed++; $display("FAIL %s_cycle%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=0", tag, i, ram_write, waddr, new_ram_data, i);
      end
      tests_run++; if (wr_ready !== 1'b0 || init_done !== 1'b0 || clear_done !== 1'b0) begin
        tests_failed++; $display("FAIL %s_flags%0d: got rdy=%b init=%b done=%b want 0 0 0", tag, i, wr_ready, init_done, clear_done);
      end
      step();
      clear_req = 1'b0;
    end
  endtask

  task automatic test_clear();
    step();
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE_F00D;
    // A clear_req in the middle of the sweep must not restart it.
    for (int i = 0; i < 32; i++) begin
      clear_req = (i == 5);
      at_neg();
      tests_run++; if (ram_write !== 1'b1 || waddr !== 5'(i) || new_ram_data !== 32'h0 || wr_ready !== 1'b0) begin
        tests_failed++; $display("FAIL clear_cycle%0d: got we=%b addr=%0d data=%h rdy=%b want 1 %0d 0 0", i, ram_write, waddr, new_ram_data, wr_ready, i);
      end
      tests_run++; if (clear_done !== 1'b0 || init_done !== 1'b0) begin
        tests_failed++; $display("FAIL clear_flags%0d: got done=%b init=%b want 0 0", i, clear_done, init_done);
      end
      step();
    end
    clear_req = 1'b0;
    at_neg();
    tests_run++; if (init_done !== 1'b1 || clear_done !== 1'b1) begin tests_failed++; $display("FAIL clear_end_flags: got init=%b done=%b want 1 1", init_done, clear_done); end
    tests_run++; if (wr_ready !== 1'b1 || ram_write !== 1'b1 || waddr !== 5'd7 || new_ram_data !== 32'hCAFE_F00D) begin
      tests_failed++; $display("FAIL held_write: got rdy=%b we=%b addr=%0d data=%h want 1 1 7 cafef00d", wr_ready, ram_write, waddr, new_ram_data);
    end
    step();
    wr_valid = 1'b0;
    at_neg();
    tests_run++; if (clear_done !== 1'b0) begin tests_failed++; $display("FAIL clear_done_pulse: got %b want 0", clear_done); end
    for (int i = 0; i < 32; i++) begin
      tests_run++; if (mem_a[i] !== ((i == 7) ? 32'hCAFE_F00D : 32'h0)) begin
        tests_failed++; $display("FAIL clear_mem%0d: got %h want %h", i, mem_a[i], (i == 7) ? 32'hCAFE_F00D : 32'h0);
      end
    end
  endtask

  task automatic test_clear_req();
    step();
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_1234; clear_req = 1'b1;
    at_neg();
    tests_run++; if (wr_ready !== 1'b0 || ram_write !== 1'b0 || init_done !== 1'b1) begin
      tests_failed++; $display("FAIL clear_req_block: got rdy=%b we=%b init=%b want 0 0 1", wr_ready, ram_write, init_done);
    end
    step();
    wr_valid = 1'b0;
    run_clear32("reclear");
    at_neg();
    tests_run++; if (clear_done !== 1'b1 || init_done !== 1'b1) begin tests_failed++; $display("FAIL reclear_end: got done=%b init=%b want 1 1", clear_done, init_done); end
    tests_run++; if (mem_a[3] !== 32'h0) begin tests_failed++; $display("FAIL reclear_mem3: got %h want 0", mem_a[3]); end
    tests_run++; if (mem_a[5] !== 32'h0) begin tests_failed++; $display("FAIL reclear_mem5: got %h want 0", mem_a[5]); end
  endtask

  task automatic test_reset_abort();
    step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      tests_run++; if (waddr !== 5'(i)) begin tests_failed++; $display("FAIL abort_pre%0d: got addr=%0d want %0d", i, waddr, i); end
      step();
    end
    rst_n = 1'b0;
    #1;
    tests_run++; if (ram_write !== 1'b0 || wr_ready !== 1'b0 || init_done !== 1'b0 || clear_done !== 1'b0) begin
      tests_failed++; $display("FAIL abort_outputs: got we=%b rdy=%b init=%b done=%b want 0 0 0 0", ram_write, wr_ready, init_done, clear_done);
    end
    step();
    step();
    rst_n = 1'b1;
    run_clear32("restart");
    at_neg();
    tests_run++; if (init_done !== 1'b1 || clear_done !== 1'b1) begin tests_failed++; $display("FAIL restart_end: got init=%b done=%b want 1 1", init_done, clear_done); end
    for (int i = 0; i < 32; i++) begin
      tests_run++; if (mem_a[i] !== 32'h0) begin tests_failed++; $display("FAIL restart_mem%0d: got %h want 0", i, mem_a[i]); end
    end
  endtask

  task automatic test_depth24();
    step();
    rst_n_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      at_neg();
      tests_run++; if (ram_write_b !== 1'b1 || waddr_b !== 5'(i) || init_done_b !== 1'b0) begin
        tests_failed++; $display("FAIL d24_cycle%0d: got we=%b addr=%0d init=%b want 1 %0d 0", i, ram_write_b, waddr_b, init_done_b, i);
      end
      step();
    end
    at_neg();
    tests_run++; if (init_done_b !== 1'b1 || clear_done_b !== 1'b1 || ram_write_b !== 1'b0) begin
      tests_failed++; $display("FAIL d24_end: got init=%b done=%b we=%b want 1 1 0", init_done_b, clear_done_b, ram_write_b);
    end
    for (int i = 0; i < 24; i++) begin
      tests_run++; if (mem_b[i] !== 32'h0) begin tests_failed++; $display("FAIL d24_mem%0d: got %h want 0", i, mem_b[i]); end
    end
  endtask
`else
  task automatic test_release();
    step();
    rst_n = 1'b1;
    at_neg();
    tests_run++; if (wr_ready !== 1'b1 || init_done !== 1'b1 || clear_done !== 1'b0) begin
      tests_failed++; $display("FAIL release_flags: got rdy=%b init=%b done=%b want 1 1 0", wr_ready, init_done, clear_done);
    end
  endtask

  task automatic test_clear_req_ignored();
    step();
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_1234; clear_req = 1'b1;
    at_neg();
    tests_run++; if (wr_ready !== 1'b1 || ram_write !== 1'b1 || waddr !== 5'd3 || new_ram_data !== 32'h1234) begin
      tests_failed++; $display("FAIL nclr_write: got rdy=%b we=%b addr=%0d data=%h want 1 1 3 1234", wr_ready, ram_write, waddr, new_ram_data);
    end
    step();
    wr_valid = 1'b0; clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      tests_run++; if (clear_done !== 1'b0 || ram_write !== 1'b0 || init_done !== 1'b1) begin
        tests_failed++; $display("FAIL nclr_idle%0d: got done=%b we=%b init=%b want 0 0 1", i, clear_done, ram_write, init_done);
      end
      step();
    end
    tests_run++; if (mem_a[3] !== 32'h0000_1234) begin tests_failed++; $display("FAIL nclr_mem3: got %h want 1234", mem_a[3]); end
  endtask

  task automatic test_depth24();
    step();
    rst_n_b = 1'b1;
    wr_valid_b = 1'b1; wr_addr_b = 5'd23; wr_data_b = 32'h2323_2323;
    at_neg();
    tests_run++; if (ram_write_b !== 1'b1 || waddr_b !== 5'd23 || wr_ready_b !== 1'b1) begin
      tests_failed++; $display("FAIL d24_write: got we=%b addr=%0d rdy=%b want 1 23 1", ram_write_b, waddr_b, wr_ready_b);
    end
    step();
    wr_valid_b = 1'b0;
    at_neg();
    tests_run++; if (mem_b[23] !== 32'h2323_2323) begin tests_failed++; $display("FAIL d24_mem23: got %h want 23232323", mem_b[23]); end
  endtask
`endif

  task automatic test_write();
    step();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    at_neg();
    tests_run++; if (wr_ready !== 1'b1 || ram_write !== 1'b1) begin tests_failed++; $display("FAIL write_hs: got rdy=%b we=%b want 1 1", wr_ready, ram_write); end
    tests_run++; if (waddr !== 5'd5 || new_ram_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_port: got addr=%0d data=%h want 5 deadbeef", waddr, new_ram_data); end
    step();
    wr_valid = 1'b0; wr_addr = 5'd12; wr_data = 32'h5555_AAAA;
    at_neg();
    tests_run++; if (mem_a[5] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_mem5: got %h want deadbeef", mem_a[5]); end
    tests_run++; if (ram_write !== 1'b0 || waddr !== 5'd12 || new_ram_data !== 32'h5555_AAAA) begin
      tests_failed++; $display("FAIL idle_port: got we=%b addr=%0d data=%h want 0 12 5555aaaa", ram_write, waddr, new_ram_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [4];
    logic [31:0] datas [4];
    addrs[0] = 5'd0;  datas[0] = 32'h1111_0000;
    addrs[1] = 5'd31; datas[1] = 32'h2222_001F;
    addrs[2] = 5'd16; datas[2] = 32'h3333_0010;
    addrs[3] = 5'd1;  datas[3] = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      wr_valid = 1'b1; wr_addr = addrs[k]; wr_data = datas[k];
      at_neg();
      tests_run++; if (ram_write !== 1'b1 || waddr !== addrs[k] || new_ram_data !== datas[k]) begin
        tests_failed++; $display("FAIL b2b_port%0d: got we=%b addr=%0d data=%h want 1 %0d %h", k, ram_write, waddr, new_ram_data, addrs[k], datas[k]);
      end
    end
    step();
    wr_valid = 1'b0;
    at_neg();
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (mem_a[addrs[k]] !== datas[k]) begin tests_failed++; $display("FAIL b2b_mem%0d: got %h want %h", k, mem_a[addrs[k]], datas[k]); end
    end
  endtask

  initial begin
    test_reset();
`ifdef LUT_RAM_CLEAR_EN
    test_clear();
    test_write();
    test_back_to_back();
    test_clear_req();
    test_reset_abort();
    test_depth24();
`else
    test_release();
    test_write();
    test_back_to_back();
    test_clear_req_ignored();
    test_depth24();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_lut_ram_write_ctrl
